// File: rtl/mux41_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 bit mux between four requesters.
// Tenure per owner is bounded by MAX_HOLD; handover between owners has no idle bubble.
module mux41_rr_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int HOLD_W   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] din,
  output logic [3:0] gnt,
  output logic       s1,
  output logic       s0,
  output logic       busy,
  output logic       y
);

  localparam logic [HOLD_W-1:0] MAX_CNT = HOLD_W'(MAX_HOLD);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state, state_nxt;
  logic [1:0]        last, last_nxt;
  logic [1:0]        sel, sel_nxt;
  logic [HOLD_W-1:0] cnt, cnt_nxt;
  logic [3:0]        gnt_nxt;
  logic              busy_nxt;
  logic              rel;
  logic [1:0]        search_base;
  logic [2:0]        pick;

  // Returns {found, index}; scans base+1 .. base+4 so the base itself is checked last.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
    logic [1:0] idx;
    rr_pick = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = base + 2'(k);
      if (r[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  assign rel         = (state == GRANT) && (!req[sel] || (cnt == MAX_CNT));
  assign search_base = rel ? sel : last;
  assign pick        = rr_pick(req, search_base);

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    sel_nxt   = sel;
    cnt_nxt   = cnt;
    gnt_nxt   = gnt;
    busy_nxt  = busy;
    case (state)
      IDLE: begin
        if (pick[2]) begin
          state_nxt = GRANT;
          sel_nxt   = pick[1:0];
          gnt_nxt   = 4'b0001 << pick[1:0];
          cnt_nxt   = HOLD_W'(1);
          busy_nxt  = 1'b1;
        end
      end
      GRANT: begin
        if (rel) begin
          last_nxt = sel;
          if (pick[2]) begin
            sel_nxt  = pick[1:0];
            gnt_nxt  = 4'b0001 << pick[1:0];
            cnt_nxt  = HOLD_W'(1);
            busy_nxt = 1'b1;
          end else begin
            // Select keeps the departing owner so the mux input stays stable while idle.
            state_nxt = IDLE;
            gnt_nxt   = 4'b0000;
            cnt_nxt   = '0;
            busy_nxt  = 1'b0;
          end
        end else begin
          cnt_nxt = cnt + HOLD_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 4'b0000;
        busy_nxt  = 1'b0;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= 2'd3;
      sel   <= 2'd0;
      cnt   <= '0;
      gnt   <= 4'b0000;
      busy  <= 1'b0;
      y     <= 1'b0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      sel   <= sel_nxt;
      cnt   <= cnt_nxt;
      gnt   <= gnt_nxt;
      busy  <= busy_nxt;
      // Data stage uses the pre-edge owner, so y trails gnt by one cycle.
      y     <= busy ? din[sel] : 1'b0;
    end
  end

  assign s1 = sel[1];
  assign s0 = sel[0];

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_gnt_busy:    assert property (@(posedge clk) disable iff (!rst_n) ((gnt != 4'b0000) == busy));
  a_gnt_sel:     assert property (@(posedge clk) disable iff (!rst_n)
                                  ((gnt == 4'b0000) || (gnt == (4'b0001 << sel))));
  a_cnt_bound:   assert property (@(posedge clk) disable iff (!rst_n) (cnt <= MAX_CNT));

endmodule

// File: tb/tb_mux41_rr_arbiter.sv
// Directed bench for mux41_rr_arbiter: reset, rotation, early release, lone requester, data path, mid-grant reset.
module tb_mux41_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] din = 4'b0000;
  logic [3:0] gnt;
  logic       s1, s0, busy, y;

  int total = 0;
  int bad   = 0;

  mux41_rr_arbiter #(.MAX_HOLD(4), .HOLD_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din),
    .gnt(gnt), .s1(s1), .s0(s0), .busy(busy), .y(y)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = 4'b0000; din = 4'b0000;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'hF; din = 4'hF;
    tick(); tick();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if ({s1, s0} !== 2'd0) begin bad++; $display("FAIL reset_sel got=%0d exp=0", {s1, s0}); end
    total++; if (y !== 1'b0) begin bad++; $display("FAIL reset_y got=%b exp=0", y); end
    rst_n = 1'b1;
    tick();
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL reset_first_gnt got=%b exp=0001", gnt); end
  endtask

  // Continues from test_reset: source 0 has held the grant for one cycle already.
  task automatic test_rotation();
    logic [3:0] exp_g;
    logic [1:0] exp_s;
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp_s = 2'((k / 4) % 4);
      exp_g = 4'b0001 << exp_s;
      total++;
      if (gnt !== exp_g || busy !== 1'b1 || {s1, s0} !== exp_s) begin
        bad++;
        $display("FAIL rotation k=%0d got gnt=%b busy=%b sel=%0d exp gnt=%b busy=1 sel=%0d",
                 k, gnt, busy, {s1, s0}, exp_g, exp_s);
      end
    end
  endtask

  task automatic test_early_release();
    do_reset();
    req = 4'b0100;
    tick();
    total++; if (gnt !== 4'b0100 || busy !== 1'b1) begin bad++; $display("FAIL early_c1 got gnt=%b busy=%b exp 0100/1", gnt, busy); end
    tick();
    total++; if (gnt !== 4'b0100 || busy !== 1'b1) begin bad++; $display("FAIL early_c2 got gnt=%b busy=%b exp 0100/1", gnt, busy); end
    req = 4'b0001;
    tick();
    total++; if (gnt !== 4'b0001 || busy !== 1'b1 || {s1, s0} !== 2'd0) begin bad++; $display("FAIL early_handover got gnt=%b busy=%b sel=%0d exp 0001/1/0", gnt, busy, {s1, s0}); end
    req = 4'b0000;
    tick();
    total++; if (gnt !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL early_idle got gnt=%b busy=%b exp 0000/0", gnt, busy); end
  endtask

  task automatic test_lone_requester();
    do_reset();
    req = 4'b0010;
    for (int k = 0; k < 10; k++) begin
      tick();
      total++;
      if (gnt !== 4'b0010 || busy !== 1'b1 || {s1, s0} !== 2'd1) begin
        bad++;
        $display("FAIL lone k=%0d got gnt=%b busy=%b sel=%0d exp 0010/1/1", k, gnt, busy, {s1, s0});
      end
    end
    req = 4'b0000;
    tick();
    total++; if (gnt !== 4'b0000 || busy !== 1'b0 || {s1, s0} !== 2'd1) begin bad++; $display("FAIL lone_release got gnt=%b busy=%b sel=%0d exp 0000/0/1", gnt, busy, {s1, s0}); end
    tick();
    total++; if (gnt !== 4'b0000 || {s1, s0} !== 2'd1) begin bad++; $display("FAIL lone_sel_hold got gnt=%b sel=%0d exp 0000/1", gnt, {s1, s0}); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_g;
    do_reset();
    req = 4'b1010;
    for (int k = 0; k < 9; k++) begin
      tick();
      exp_g = ((k / 4) % 2 == 0) ? 4'b0010 : 4'b1000;
      total++;
      if (gnt !== exp_g || busy !== 1'b1) begin
        bad++;
        $display("FAIL b2b k=%0d got gnt=%b busy=%b exp %b/1", k, gnt, busy, exp_g);
      end
    end
  endtask

  task automatic test_data();
    do_reset();
    req = 4'b0100; din = 4'b0000;
    tick();
    total++; if (gnt !== 4'b0100 || y !== 1'b0) begin bad++; $display("FAIL data_first got gnt=%b y=%b exp 0100/0", gnt, y); end
    din = 4'b0100;
    tick();
    total++; if (y !== 1'b1) begin bad++; $display("FAIL data_one got y=%b exp 1", y); end
    din = 4'b0000;
    tick();
    total++; if (y !== 1'b0) begin bad++; $display("FAIL data_zero got y=%b exp 0", y); end
    din = 4'b1011;
    tick();
    total++; if (y !== 1'b0) begin bad++; $display("FAIL data_other_bits got y=%b exp 0", y); end
    din = 4'b0100;
    tick();
    total++; if (y !== 1'b1 || gnt !== 4'b0100) begin bad++; $display("FAIL data_regrant got y=%b gnt=%b exp 1/0100", y, gnt); end
    req = 4'b0000; din = 4'hF;
    tick();
    total++; if (y !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL data_last_sample got y=%b busy=%b exp 1/0", y, busy); end
    tick();
    total++; if (y !== 1'b0) begin bad++; $display("FAIL data_idle1 got y=%b exp 0", y); end
    tick();
    total++; if (y !== 1'b0) begin bad++; $display("FAIL data_idle2 got y=%b exp 0", y); end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 4'b1000;
    tick(); tick();
    total++; if (gnt !== 4'b1000 || {s1, s0} !== 2'd3) begin bad++; $display("FAIL mid_pre got gnt=%b sel=%0d exp 1000/3", gnt, {s1, s0}); end
    rst_n = 1'b0;
    tick();
    total++; if (gnt !== 4'b0000 || busy !== 1'b0 || {s1, s0} !== 2'd0 || y !== 1'b0) begin bad++; $display("FAIL mid_abort got gnt=%b busy=%b sel=%0d y=%b exp 0000/0/0/0", gnt, busy, {s1, s0}, y); end
    rst_n = 1'b1; req = 4'b1001;
    tick();
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL mid_after got gnt=%b exp 0001", gnt); end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_early_release();
    test_lone_requester();
    test_back_to_back();
    test_data();
    test_reset_mid_grant();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
